// File: rtl/seven_seg_pkg.sv
// Shared types, character codes and the code-to-segment decode for the seven-segment scanner.
package seven_seg_pkg;

    localparam int unsigned CODE_W = 5;
    localparam int unsigned SEG_W  = 7;

    typedef logic [CODE_W-1:0] char_code_t;
    typedef logic [SEG_W-1:0]  seg7_t;

    localparam char_code_t CODE_SEG_A = 5'd16;
    localparam char_code_t CODE_SEG_B = 5'd17;
    localparam char_code_t CODE_SEG_C = 5'd18;
    localparam char_code_t CODE_SEG_D = 5'd19;
    localparam char_code_t CODE_SEG_E = 5'd20;
    localparam char_code_t CODE_SEG_F = 5'd21;
    localparam char_code_t CODE_SEG_G = 5'd22;
    localparam char_code_t CODE_BLANK = 5'd23;
    localparam char_code_t CODE_H     = 5'd24;
    localparam char_code_t CODE_L     = 5'd25;
    localparam char_code_t CODE_R     = 5'd26;
    localparam char_code_t CODE_LC_L  = 5'd27;
    localparam char_code_t CODE_LC_R  = 5'd28;

    localparam seg7_t SEG_OFF = 7'b0000000;

    // Active-high segment pattern, bit 6 = a ... bit 0 = g.
    function automatic seg7_t seg7_decode(input char_code_t code);
        seg7_t seg;
        case (code)
            5'd0:       seg = 7'b1111110;
            5'd1:       seg = 7'b0110000;
            5'd2:       seg = 7'b1101101;
            5'd3:       seg = 7'b1111001;
            5'd4:       seg = 7'b0110011;
            5'd5:       seg = 7'b1011011;
            5'd6:       seg = 7'b1011111;
            5'd7:       seg = 7'b1110000;
            5'd8:       seg = 7'b1111111;
            5'd9:       seg = 7'b1111011;
            5'd10:      seg = 7'b1110111;
            5'd11:      seg = 7'b0011111;
            5'd12:      seg = 7'b1001110;
            5'd13:      seg = 7'b0111101;
            5'd14:      seg = 7'b1001111;
            5'd15:      seg = 7'b1000111;
            CODE_SEG_A: seg = 7'b1000000;
            CODE_SEG_B: seg = 7'b0100000;
            CODE_SEG_C: seg = 7'b0010000;
            CODE_SEG_D: seg = 7'b0001000;
            CODE_SEG_E: seg = 7'b0000100;
            CODE_SEG_F: seg = 7'b0000010;
            CODE_SEG_G: seg = 7'b0000001;
            CODE_H:     seg = 7'b0110111;
            CODE_L:     seg = 7'b0001110;
            CODE_R:     seg = 7'b1000110;
            CODE_LC_L:  seg = 7'b0000110;
            CODE_LC_R:  seg = 7'b0000101;
            default:    seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational character-code to segment ROM.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  char_code_t code,
    output seg7_t      seg_c
);

    assign seg_c = seg7_decode(code);

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner: frame-synchronous display update, leading-zero blanking, PWM dimming.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 1024,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic [CODE_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]        dp_in,
    input  logic                         lz_en,
    input  logic [3:0]                   brightness,
    output logic [SEG_W-1:0]             seg_out,
    output logic                         dp_out,
    output logic [NUM_DIGITS-1:0]        an_out,
    output logic                         frame_start
);

    localparam int unsigned PSC_W  = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned DATA_W = CODE_W * NUM_DIGITS;

    logic [PSC_W-1:0]      psc;
    logic [IDX_W-1:0]      idx;
    logic                  psc_wrap;
    logic                  idx_last;
    logic                  frame_wrap;
    logic                  fs_next;

    logic [DATA_W-1:0]     shadow_codes;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic                  pending;
    logic [DATA_W-1:0]     disp_codes;
    logic [NUM_DIGITS-1:0] disp_dp;

    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  lz_run;
    char_code_t            act_code;
    seg7_t                 act_seg;
    logic                  pwm_on;
    logic [NUM_DIGITS-1:0] an_sel;

    assign psc_wrap   = (psc == PSC_W'(SCAN_DIV - 1));
    assign idx_last   = (idx == IDX_W'(NUM_DIGITS - 1));
    assign frame_wrap = psc_wrap && idx_last;
    // Registered pulse lands in the wrap cycle itself, so a load seen with it hits the boundary.
    assign fs_next    = (psc == PSC_W'(SCAN_DIV - 2)) && idx_last;

    // Prescaler, digit index and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc         <= '0;
            idx         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= fs_next;
            if (psc_wrap) begin
                psc <= '0;
                idx <= idx_last ? '0 : idx + IDX_W'(1);
            end else begin
                psc <= psc + PSC_W'(1);
            end
        end
    end

    // Shadow capture and tear-free display update at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_codes <= {NUM_DIGITS{CODE_BLANK}};
            shadow_dp    <= '0;
            pending      <= 1'b0;
            disp_codes   <= {NUM_DIGITS{CODE_BLANK}};
            disp_dp      <= '0;
        end else begin
            if (load) begin
                shadow_codes <= digits_in;
                shadow_dp    <= dp_in;
            end
            if (frame_wrap) begin
                pending <= 1'b0;
                if (load) begin
                    disp_codes <= digits_in;
                    disp_dp    <= dp_in;
                end else if (pending) begin
                    disp_codes <= shadow_codes;
                    disp_dp    <= shadow_dp;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Blank the run of zero codes from the top digit down; digit 0 always shows.
    always_comb begin
        lz_mask = '0;
        lz_run  = lz_en;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            lz_run     = lz_run && (disp_codes[CODE_W*i +: CODE_W] == '0);
            lz_mask[i] = lz_run;
        end
    end

    assign act_code = lz_mask[idx] ? CODE_BLANK : disp_codes[CODE_W*idx +: CODE_W];

    seven_seg_decode u_decode (
        .code  (act_code),
        .seg_c (act_seg)
    );

    assign pwm_on = ((32'(psc) << 4) < ((32'(brightness) + 32'd1) * SCAN_DIV));
    assign an_sel = pwm_on ? (NUM_DIGITS'(1) << idx) : '0;

    // Output register with polarity applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= {SEG_W{ACTIVE_LOW}};
            dp_out  <= ACTIVE_LOW;
            an_out  <= {NUM_DIGITS{ACTIVE_LOW}};
        end else begin
            seg_out <= act_seg ^ {SEG_W{ACTIVE_LOW}};
            dp_out  <= disp_dp[idx] ^ ACTIVE_LOW;
            an_out  <= an_sel ^ {NUM_DIGITS{ACTIVE_LOW}};
        end
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed digit positions; legal range 2..16.
REQ-002 Parameter SCAN_DIV, default 1024: clock cycles per digit slot; SHALL be a multiple of 16 and at least 16.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 means seg_out, dp_out and an_out are driven low to light.
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 load  input  1  one-cycle request to capture digits_in and dp_in.
REQ-007 digits_in  input  5*NUM_DIGITS  5-bit character codes; bits [4:0] are digit 0, the least significant position.
REQ-008 dp_in  input  NUM_DIGITS  decimal-point enables, one per digit.
REQ-009 lz_en  input  1  leading-zero suppression enable.
REQ-010 brightness  input  4  PWM duty level: 0 is dimmest, 15 is full.
REQ-011 seg_out  output  7  segments a..g; bit 6 is a, bit 0 is g.
REQ-012 dp_out  output  1  decimal point for the active digit.
REQ-013 an_out  output  NUM_DIGITS  one-hot anode select; bit i selects digit i.
REQ-014 frame_start  output  1  one-cycle pulse when the digit index wraps to 0.

Function
REQ-015 Character decode: codes 0-9 display '0'-'9' and codes 10-15 display 'A'-'F'.
REQ-016 Codes 16-22 each light exactly one segment, a through g in that order.
REQ-017 Codes 24, 25, 26, 27 and 28 display 'H', 'L', 'R', 'l' and 'r' respectively.
REQ-018 Code 23 and codes 29-31 display blank.
REQ-019 Segment patterns, active-high before polarity: '0'=1111110, 'A'=1110111, 'H'=0110111, 'r'=0000101; code 17 SHALL be 0100000.
REQ-020 Prescaler counts 0..SCAN_DIV-1 and wraps; the digit index increments on the wrap and itself wraps NUM_DIGITS-1 -> 0.
REQ-021 frame_start SHALL be asserted for exactly the cycle in which the index transitions NUM_DIGITS-1 -> 0.
REQ-022 load SHALL copy digits_in and dp_in into a shadow register and set a pending flag in the same cycle.
REQ-023 The display register SHALL update only at a frame boundary (no tearing), copying the shadow register if pending is set, and SHALL then clear pending.
REQ-024 If load coincides with the frame boundary, the display register SHALL take digits_in/dp_in directly and pending SHALL end cleared.
REQ-025 Repeated loads within one frame: the last load wins.
REQ-026 Leading-zero suppression, lz_en=1: starting from digit NUM_DIGITS-1 downward, every code-0 digit before the first nonzero code displays blank.
REQ-027 Digit 0 is never suppressed; dp is unaffected by suppression.
REQ-028 lz_en is sampled combinationally against the display register.
REQ-029 PWM: an_out for the active digit is asserted only while prescaler*16 < (brightness+1)*SCAN_DIV; otherwise all anodes are inactive.
REQ-030 With brightness=15, the anode is on for the whole slot.
REQ-031 seg_out, dp_out and an_out SHALL be registered, reflecting the index/prescaler state with 1 cycle latency.
REQ-032 At most one anode is active in any cycle.
REQ-033 Polarity: when ACTIVE_LOW=1, all three output buses are bitwise inverted.

Reset
REQ-034 On rst_n low, asynchronously: prescaler=0, index=0, pending=0, frame_start=0.
REQ-035 On rst_n low, asynchronously: shadow and display registers = code 23 (blank) with dp=0.
REQ-036 On rst_n low, asynchronously: seg_out, dp_out and an_out go to the unlit level.
REQ-037 Reset mid-frame SHALL discard any pending load.
REQ-038 After rst_n rises, the first scan slot begins at digit 0.

Structure
REQ-039 Shared package seven_seg_pkg SHALL hold: char_code_t (5-bit), seg7_t (7-bit), named code constants (CODE_BLANK=23, CODE_H=24, etc.), and the decode function.
REQ-040 Sub-module seven_seg_decode: purely combinational code-to-segment ROM, instantiated once on the muxed active digit.

Verification
REQ-041 Bench parameters: NUM_DIGITS=4, SCAN_DIV=16, ACTIVE_LOW=0; brightness=15 unless stated.
REQ-042 Reset release -> an_out cycles 0001, 0010, 0100, 1000 at 16 cycles each; seg_out=0000000 throughout; frame_start pulses every 64 cycles.
REQ-043 load digits_in={3,2,1,0} mid-frame -> the display is unchanged until the next frame_start; thereafter digit 0 shows 1111110 and digit 3 shows 1111001.
REQ-044 lz_en=1, codes {0,0,5,0} -> digits 3 and 2 blank, digit 1 shows 1011011, digit 0 shows 1111110.
REQ-045 lz_en=1, codes {0,0,0,0} -> only digit 0 shows 1111110.
REQ-046 brightness=3 -> the active anode is high for 4 of every 16 slot cycles.
REQ-047 load asserted in the frame_start cycle -> new data visible in that frame.
REQ-048 rst_n pulsed low mid-frame -> outputs unlit immediately, pending load lost.
REQ-049 Sweep of all 32 codes -> seg_out matches the REQ-015..REQ-019 table, code 17 = 0100000.
